// File: rtl/riscv_mem_arb_if.sv
// Signal bundle between the fetch requester, the data requester, the shared
// memory bus and the arbiter. The arbiter uses the slave view; the master
// view drives the requests and the bus responses.
interface riscv_mem_arb_if #(
  parameter int XLEN = 32
);
  // fetch requester
  logic            imem_req;
  logic [XLEN-1:0] imem_adr;
  logic [XLEN-1:0] imem_q;
  logic            imem_ack;
  logic            imem_err;

  // data requester
  logic            dmem_req;
  logic [XLEN-1:0] dmem_adr;
  logic [XLEN-1:0] dmem_d;
  logic            dmem_we;
  logic [2:0]      dmem_size;
  logic [XLEN-1:0] dmem_q;
  logic            dmem_ack;
  logic            dmem_err;

  // shared memory bus
  logic            bus_req;
  logic [XLEN-1:0] bus_adr;
  logic [XLEN-1:0] bus_d;
  logic            bus_we;
  logic [2:0]      bus_size;
  logic            bus_ack;
  logic            bus_err;
  logic [XLEN-1:0] bus_q;

  modport slave (
    input  imem_req, imem_adr,
    output imem_q, imem_ack, imem_err,
    input  dmem_req, dmem_adr, dmem_d, dmem_we, dmem_size,
    output dmem_q, dmem_ack, dmem_err,
    output bus_req, bus_adr, bus_d, bus_we, bus_size,
    input  bus_ack, bus_err, bus_q
  );

  modport master (
    output imem_req, imem_adr,
    input  imem_q, imem_ack, imem_err,
    output dmem_req, dmem_adr, dmem_d, dmem_we, dmem_size,
    input  dmem_q, dmem_ack, dmem_err,
    input  bus_req, bus_adr, bus_d, bus_we, bus_size,
    output bus_ack, bus_err, bus_q
  );
endinterface

// File: rtl/riscv_mem_arb.sv
// Two-requester memory bus arbiter: instruction fetch and data access share one
// bus. Data normally wins a tie; fetch wins after STARVE_LIM consecutive lost
// ties. A watchdog turns a bus that never answers into an error to the owner.
module riscv_mem_arb #(
  parameter int XLEN       = 32,
  parameter int STARVE_LIM = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic           clk,
  input  logic           rst,
  riscv_mem_arb_if.slave io,
  output logic           arb_owner
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    IBUSY = 2'd1,
    DBUSY = 2'd2
  } state_t;

  // Transfer-size encoding for a full 32-bit word.
  localparam logic [2:0]      SIZE_WORD  = 3'b010;
  localparam logic [3:0]      STARVE_MAX = 4'd15;
  localparam logic [3:0]      STARVE_THR = 4'(STARVE_LIM);
  // The watchdog holds (busy cycles - 1), so the final allowed cycle sees TIMEOUT-1.
  localparam logic [9:0]      WDOG_LAST  = 10'(TIMEOUT - 1);
  localparam logic [XLEN-1:0] ZERO_WORD  = '0;

  state_t     state_reg;
  logic [3:0] starve_cnt_reg;
  logic [9:0] wdog_reg;

  logic busy;
  logic timeout_hit;
  logic owner_ack;
  logic owner_err;
  logic done;

  // Completion decode: err beats ack, and the watchdog only fires when the bus is silent.
  always_comb begin
    busy        = (state_reg != IDLE);
    timeout_hit = busy && (wdog_reg == WDOG_LAST) && !io.bus_ack && !io.bus_err;
    owner_err   = busy && (io.bus_err || timeout_hit);
    owner_ack   = busy && io.bus_ack && !io.bus_err;
    done        = owner_ack || owner_err;
  end

  // Arbitration FSM with the starvation counter and the bus watchdog.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      starve_cnt_reg <= 4'd0;
      wdog_reg       <= 10'd0;
    end else begin
      case (state_reg)
        IDLE: begin
          wdog_reg <= 10'd0;
          if (io.dmem_req && (!io.imem_req || (starve_cnt_reg < STARVE_THR))) begin
            state_reg <= DBUSY;
            if (io.imem_req && (starve_cnt_reg != STARVE_MAX)) begin
              starve_cnt_reg <= starve_cnt_reg + 4'd1;
            end
          end else if (io.imem_req) begin
            state_reg      <= IBUSY;
            starve_cnt_reg <= 4'd0;
          end
          if (!io.imem_req) begin
            starve_cnt_reg <= 4'd0;
          end
        end
        IBUSY, DBUSY: begin
          if (done) begin
            state_reg <= IDLE;
            wdog_reg  <= 10'd0;
          end else begin
            wdog_reg <= wdog_reg + 10'd1;
          end
        end
        default: begin
          state_reg <= IDLE;
          wdog_reg  <= 10'd0;
        end
      endcase
    end
  end

  // Bus request and owner come straight from the state register.
  assign io.bus_req = busy;
  assign arb_owner  = (state_reg == DBUSY);

  // Forward the owner's request fields onto the bus; the idle bus is driven to zero.
  always_comb begin
    io.bus_adr  = ZERO_WORD;
    io.bus_d    = ZERO_WORD;
    io.bus_we   = 1'b0;
    io.bus_size = 3'b000;
    case (state_reg)
      IBUSY: begin
        io.bus_adr  = io.imem_adr;
        io.bus_size = SIZE_WORD;
      end
      DBUSY: begin
        io.bus_adr  = io.dmem_adr;
        io.bus_d    = io.dmem_d;
        io.bus_we   = io.dmem_we;
        io.bus_size = io.dmem_size;
      end
      default: ;
    endcase
  end

  // Route completion to the owner only; read data is shared and qualified by ack.
  assign io.imem_ack = (state_reg == IBUSY) && owner_ack;
  assign io.imem_err = (state_reg == IBUSY) && owner_err;
  assign io.dmem_ack = (state_reg == DBUSY) && owner_ack;
  assign io.dmem_err = (state_reg == DBUSY) && owner_err;
  assign io.imem_q   = io.bus_q;
  assign io.dmem_q   = io.bus_q;

endmodule

// File: tb/tb_riscv_mem_arb.sv
// Scoreboard bench for riscv_mem_arb: stimulus pushes expected completions,
// a negedge monitor pops and compares every ack/err the arbiter produces.
module tb_riscv_mem_arb;
  localparam int         XLEN    = 32;
  localparam logic [2:0] SZ_WORD = 3'b010;

  // response kinds for the bus model
  localparam int K_ACK   = 0;
  localparam int K_ERR   = 1;
  localparam int K_BOTH  = 2;
  localparam int K_NEVER = 3;

  // expected flag patterns {imem_ack, imem_err, dmem_ack, dmem_err}
  localparam logic [3:0] F_IACK = 4'b1000;
  localparam logic [3:0] F_IERR = 4'b0100;
  localparam logic [3:0] F_DACK = 4'b0010;
  localparam logic [3:0] F_DERR = 4'b0001;

  typedef struct packed {
    logic [3:0]  flags;
    logic [31:0] q;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic arb_owner;

  riscv_mem_arb_if #(.XLEN(XLEN)) bif ();

  riscv_mem_arb #(
    .XLEN(XLEN),
    .STARVE_LIM(4),
    .TIMEOUT(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .io(bif.slave),
    .arb_owner(arb_owner)
  );

  always #5 clk = ~clk;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  int          rsp_delay = 1;
  int          rsp_kind  = K_ACK;
  logic [31:0] rsp_data  = 32'h0;
  int          busy_cnt  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", name, act, want);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic push_exp(input logic [3:0] flags, input logic [31:0] q);
    exp_t e;
    e.flags = flags;
    e.q     = q;
    sb.push_back(e);
  endtask

  // Called at the negedge of the first busy cycle; n = busy cycle of completion.
  task automatic wait_done(input bit is_d, input int budget, output int n);
    n = 1;
    while (!(is_d ? (bif.dmem_ack | bif.dmem_err) : (bif.imem_ack | bif.imem_err)) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!(is_d ? (bif.dmem_ack | bif.dmem_err) : (bif.imem_ack | bif.imem_err))) begin
      total++;
      bad++;
      $display("FAIL wait_done: no completion after %0d cycles, want one", n);
    end
  endtask

  // Bus model: answers in the rsp_delay-th busy cycle with the configured kind.
  initial begin
    bif.bus_ack = 1'b0;
    bif.bus_err = 1'b0;
    bif.bus_q   = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      if (bif.bus_req) begin
        busy_cnt++;
        bif.bus_ack = (rsp_kind == K_ACK || rsp_kind == K_BOTH) && (busy_cnt == rsp_delay);
        bif.bus_err = (rsp_kind == K_ERR || rsp_kind == K_BOTH) && (busy_cnt == rsp_delay);
        bif.bus_q   = (bif.bus_ack || bif.bus_err) ? rsp_data : 32'h0;
      end else begin
        busy_cnt    = 0;
        bif.bus_ack = 1'b0;
        bif.bus_err = 1'b0;
        bif.bus_q   = 32'h0;
      end
    end
  end

  // Monitor: every completion seen must match the oldest expectation.
  initial begin
    exp_t        e;
    logic [3:0]  act_flags;
    logic [31:0] act_q;
    forever begin
      @(negedge clk);
      act_flags = {bif.imem_ack, bif.imem_err, bif.dmem_ack, bif.dmem_err};
      if (act_flags != 4'b0000) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL resp_unexpected: got flags=%b want none", act_flags);
        end else begin
          e     = sb.pop_front();
          act_q = (e.flags[3] | e.flags[2]) ? bif.imem_q : bif.dmem_q;
          chk("resp_flags", {28'h0, act_flags}, {28'h0, e.flags});
          chk("resp_q", act_q, e.q);
        end
      end
    end
  end

  // Global time bound.
  initial begin
    #200000;
    $display("FAIL global_timeout: bench still running, want finished");
    $fatal(1, "timeout");
  end

  // Stimulus.
  initial begin
    int n;
    int dgr;
    bit fin;
    logic prev_req;

    bif.imem_req  = 1'b0;
    bif.imem_adr  = 32'h0;
    bif.dmem_req  = 1'b0;
    bif.dmem_adr  = 32'h0;
    bif.dmem_d    = 32'h0;
    bif.dmem_we   = 1'b0;
    bif.dmem_size = 3'b000;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_bus_req", {31'h0, bif.bus_req}, 32'h0);
    chk("rst_owner", {31'h0, arb_owner}, 32'h0);
    chk("rst_acks", {28'h0, bif.imem_ack, bif.imem_err, bif.dmem_ack, bif.dmem_err}, 32'h0);
    chk("rst_starve", {28'h0, dut.starve_cnt_reg}, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // single fetch, ack in 3rd busy cycle
    rsp_kind = K_ACK; rsp_delay = 3; rsp_data = 32'h0000_0013;
    push_exp(F_IACK, 32'h0000_0013);
    chk("fetch_idle_before", {31'h0, bif.bus_req}, 32'h0);
    bif.imem_req = 1'b1; bif.imem_adr = 32'h200;
    @(negedge clk);
    chk("fetch_bus_req", {31'h0, bif.bus_req}, 32'h1);
    chk("fetch_owner", {31'h0, arb_owner}, 32'h0);
    chk("fetch_bus_adr", bif.bus_adr, 32'h200);
    chk("fetch_bus_we_d", {31'h0, bif.bus_we} | bif.bus_d, 32'h0);
    chk("fetch_bus_size", {29'h0, bif.bus_size}, {29'h0, SZ_WORD});
    wait_done(1'b0, 20, n);
    chk("fetch_latency", n, 3);
    bif.imem_req = 1'b0;
    @(negedge clk);
    chk("fetch_idle_after", {31'h0, bif.bus_req}, 32'h0);

    // simultaneous request: data first, then fetch after one idle cycle
    rsp_kind = K_ACK; rsp_delay = 2; rsp_data = 32'hA5A5_A5A5;
    push_exp(F_DACK, 32'hA5A5_A5A5);
    push_exp(F_IACK, 32'hA5A5_A5A5);
    bif.imem_req = 1'b1; bif.imem_adr = 32'h200;
    bif.dmem_req = 1'b1; bif.dmem_adr = 32'h1000; bif.dmem_d = 32'hDEAD_BEEF;
    bif.dmem_we = 1'b1; bif.dmem_size = SZ_WORD;
    @(negedge clk);
    chk("both_owner_data", {31'h0, arb_owner}, 32'h1);
    chk("both_bus_d", bif.bus_d, 32'hDEAD_BEEF);
    chk("both_bus_adr", bif.bus_adr, 32'h1000);
    chk("both_bus_we", {31'h0, bif.bus_we}, 32'h1);
    wait_done(1'b1, 20, n);
    bif.dmem_req = 1'b0; bif.dmem_we = 1'b0;
    @(negedge clk);
    chk("both_gap_idle", {31'h0, bif.bus_req}, 32'h0);
    @(negedge clk);
    chk("both_fetch_req", {31'h0, bif.bus_req}, 32'h1);
    chk("both_fetch_owner", {31'h0, arb_owner}, 32'h0);
    chk("both_fetch_adr", bif.bus_adr, 32'h200);
    wait_done(1'b0, 20, n);
    bif.imem_req = 1'b0;
    @(negedge clk);

    // starvation: exactly 4 data grants, then fetch
    rsp_kind = K_ACK; rsp_delay = 1; rsp_data = 32'h1122_3344;
    repeat (4) push_exp(F_DACK, 32'h1122_3344);
    push_exp(F_IACK, 32'h1122_3344);
    bif.imem_req = 1'b1; bif.imem_adr = 32'h204;
    bif.dmem_req = 1'b1; bif.dmem_adr = 32'h2000; bif.dmem_we = 1'b0;
    dgr = 0; fin = 1'b0; prev_req = bif.bus_req;
    for (int c = 0; c < 60 && !fin; c++) begin
      @(negedge clk);
      if (bif.bus_req && !prev_req) begin
        if (arb_owner) begin
          dgr++;
        end else begin
          chk("starve_data_grants", dgr, 4);
          chk("starve_cnt_clear", {28'h0, dut.starve_cnt_reg}, 32'h0);
          bif.dmem_req = 1'b0;
        end
      end
      if (bif.imem_ack | bif.imem_err) begin
        bif.imem_req = 1'b0;
        fin = 1'b1;
      end
      prev_req = bif.bus_req;
    end
    if (!fin) begin
      total++; bad++;
      $display("FAIL starve_fetch: fetch never completed, want completion");
    end
    bif.dmem_req = 1'b0;
    @(negedge clk);

    // error precedence: ack and err together in DBUSY
    rsp_kind = K_BOTH; rsp_delay = 2; rsp_data = 32'h0BAD_0BAD;
    push_exp(F_DERR, 32'h0BAD_0BAD);
    bif.dmem_req = 1'b1; bif.dmem_adr = 32'h40; bif.dmem_we = 1'b0; bif.dmem_size = 3'b000;
    @(negedge clk);
    chk("errp_bus_size", {29'h0, bif.bus_size}, 32'h0);
    wait_done(1'b1, 20, n);
    bif.dmem_req = 1'b0;
    @(negedge clk);

    // watchdog: bus never answers a fetch
    rsp_kind = K_NEVER; rsp_delay = 1; rsp_data = 32'h0;
    push_exp(F_IERR, 32'h0);
    bif.imem_req = 1'b1; bif.imem_adr = 32'h300;
    @(negedge clk);
    wait_done(1'b0, 30, n);
    chk("timeout_cycle", n, 8);
    bif.imem_req = 1'b0;
    @(negedge clk);
    chk("timeout_idle", {31'h0, bif.bus_req}, 32'h0);

    // reset mid-transaction, then re-grant of the held request
    rsp_kind = K_NEVER;
    bif.dmem_req = 1'b1; bif.dmem_adr = 32'h3000; bif.dmem_we = 1'b1; bif.dmem_d = 32'h5555_AAAA;
    bif.dmem_size = SZ_WORD;
    @(negedge clk);
    chk("rmid_busy", {31'h0, bif.bus_req}, 32'h1);
    rst = 1'b1;
    @(negedge clk);
    chk("rmid_bus_req", {31'h0, bif.bus_req}, 32'h0);
    chk("rmid_owner", {31'h0, arb_owner}, 32'h0);
    chk("rmid_dmem_resp", {30'h0, bif.dmem_ack, bif.dmem_err}, 32'h0);
    @(negedge clk);
    chk("rmid_wdog", {22'h0, dut.wdog_reg}, 32'h0);
    rsp_kind = K_ACK; rsp_delay = 1; rsp_data = 32'h7777_0001;
    push_exp(F_DACK, 32'h7777_0001);
    rst = 1'b0;
    @(negedge clk);
    chk("rmid_regrant_req", {31'h0, bif.bus_req}, 32'h1);
    chk("rmid_regrant_owner", {31'h0, arb_owner}, 32'h1);
    wait_done(1'b1, 20, n);
    bif.dmem_req = 1'b0; bif.dmem_we = 1'b0;
    repeat (3) @(negedge clk);

    chk("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/riscv_mem_arb.md
RISCV_MEM_ARB -- requirements
Module: riscv_mem_arb

Interface
REQ-001 Parameter: XLEN, default 32, width of addresses and data.
REQ-002 Parameter: STARVE_LIM, default 4, consecutive lost arbitrations after which the fetch side wins (range 1..15).
REQ-003 Parameter: TIMEOUT, default 255, bus-busy cycles before a watchdog error (range 1..1023).
REQ-004 Clock and reset: one clock, reset synchronous and active-high. Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
REQ-005 Fetch requester ports:
- imem_req  in  1  fetch request, held until imem_ack or imem_err.
- imem_adr  in  XLEN  fetch address, stable while imem_req is high.
- imem_q  out  XLEN  read data, equal to bus_q.
- imem_ack  out  1  fetch completion.
- imem_err  out  1  fetch error.
REQ-006 Data requester ports:
- dmem_req  in  1  data request, held until dmem_ack or dmem_err.
- dmem_adr  in  XLEN  data address.
- dmem_d  in  XLEN  write data.
- dmem_we  in  1  write enable.
- dmem_size  in  3  biu_size_t transfer size.
- dmem_q  out  XLEN  read data, equal to bus_q.
- dmem_ack  out  1  data completion.
- dmem_err  out  1  data error.
REQ-007 Shared memory bus ports:
- bus_req  out  1  bus request.
- bus_adr  out  XLEN  bus address.
- bus_d  out  XLEN  bus write data.
- bus_we  out  1  bus write enable.
- bus_size  out  3  bus transfer size.
- bus_ack  in  1  bus completion.
- bus_err  in  1  bus error.
- bus_q  in  XLEN  bus read data.
REQ-008 Status port: arb_owner  out  1  current owner, 0 = fetch, 1 = data, valid while bus_req is high.

Function
REQ-009 The FSM has exactly three states: IDLE, IBUSY and DBUSY; the state register is the only source of bus_req (bus_req = state!=IDLE, glitch-free).
REQ-010 IDLE to grant:
- If only dmem_req is high, the next state is DBUSY.
- If only imem_req is high, the next state is IBUSY.
- If both are high, the next state is DBUSY, unless starve_cnt >= STARVE_LIM, in which case it is IBUSY.
REQ-011 In IBUSY, the bus carries:
- bus_adr = imem_adr, bus_we = 0, bus_d = 0.
- bus_size = WORD.
REQ-012 In DBUSY, bus_adr, bus_d, bus_we and bus_size equal the dmem_* inputs combinationally.
REQ-013 Response routing to the owner:
- bus_ack goes combinationally to the owner's *_ack.
- bus_err goes combinationally to the owner's *_err.
- The non-owner's ack and err are 0.
- In IDLE, all acks and errs are 0 and bus_ack/bus_err are ignored.
REQ-014 If bus_ack and bus_err are both high in the same cycle, the owner sees err=1 and ack=0.
REQ-015 On owner ack or err, the next state is IDLE; this gives one mandatory IDLE cycle between transactions (bus_req low for at least 1 cycle).
REQ-016 Latency: a request seen in IDLE at cycle N gives bus_req=1 at N+1; the owner's ack appears in the same cycle as bus_ack.
REQ-017 starve_cnt (4 bit):
- It increments, saturating at 15, each cycle the FSM leaves IDLE for DBUSY while imem_req is high.
- It clears when IBUSY is entered or when imem_req is low in IDLE.
REQ-018 Watchdog (10 bit):
- It counts cycles spent in IBUSY/DBUSY and clears on entering IDLE.
- When it reaches TIMEOUT with no bus_ack/bus_err, the owner receives a 1-cycle *_err in that cycle, and the FSM goes to IDLE.
REQ-019 A requester dropping its req while it owns the bus is a protocol violation; the arbiter still completes the transaction and discards nothing.
REQ-020 imem_q and dmem_q always equal bus_q; only ack/err qualify them.

Reset
REQ-021 With rst high at a clk edge:
- The state becomes IDLE, starve_cnt becomes 0 and the watchdog becomes 0.
- From that edge, bus_req=0, arb_owner=0 and all acks/errs are 0.
REQ-022 Reset mid-transaction abandons the bus transaction without an ack or err to the requester; an outstanding requester must re-request.
REQ-023 Requests present during reset are arbitrated normally in the first cycle after rst falls.

Verification
REQ-024 Single fetch: imem_req=1, adr=0x200, bus_ack at the 3rd BUSY cycle with bus_q=0x00000013 -> bus_req rises 1 cycle after the request, imem_ack=1 with imem_q=0x13, and bus_req=0 the next cycle.
REQ-025 Simultaneous request: imem_req=dmem_req=1 in IDLE, dmem_we=1, adr=0x1000, d=0xDEADBEEF -> DBUSY first, bus_d=0xDEADBEEF, and IBUSY after one IDLE cycle.
REQ-026 Starvation: imem_req held while dmem_req re-requests continuously, STARVE_LIM=4 -> exactly 4 data grants, then IBUSY, and starve_cnt=0.
REQ-027 Error precedence: bus_ack=bus_err=1 in DBUSY -> dmem_err=1, dmem_ack=0, imem_ack=imem_err=0.
REQ-028 Timeout: TIMEOUT=8, bus never acks in IBUSY -> imem_err=1 in the 8th BUSY cycle, then IDLE.
REQ-029 Reset mid-transaction: rst high in DBUSY -> bus_req=0 and dmem_ack=dmem_err=0 after the edge; a held dmem_req is re-granted 1 cycle after rst falls.
